rr_grant_encoder: RTL

Round-robin arbiter that shares one resource among 8 requesters and sequences ownership of it. It registers a one-hot grant vector and the matching 3-bit encoded index (index 0 for bit 0 through index 7 for bit 7). Ownership is held until the owner releases it, drops its request, or a hold-timeout expires. It sits in front of any shared datapath that needs both a one-hot select and a binary select.

---
 rtl/rr_grant_encoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter for 8 requesters with registered one-hot and binary grant.
// An owner keeps the grant until it releases, drops its request, or hits the hold limit.
module rr_grant_encoder #(
  parameter int MAX_HOLD = 16,
  parameter int N        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_idx,
  output logic         grant_valid,
  output logic         timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // First set request bit searching upward from p, wrapping past 7 back to 0.
  function automatic logic [2:0] rr_pick(input logic [N-1:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    for (int k = N - 1; k >= 0; k--) begin
      idx     = p + 3'(k);
      rr_pick = r[idx] ? idx : rr_pick;
    end
  endfunction

  state_t       state_r, state_s;
  logic [N-1:0] grant_r, grant_s;
  logic [2:0]   idx_r, idx_s;
  logic         valid_r, valid_s;
  logic         timeout_r, timeout_s;
  logic [2:0]   ptr_r, ptr_s;
  logic [7:0]   cnt_r, cnt_s;
  logic [2:0]   win_s;
  logic         owner_req_s;

  assign win_s       = rr_pick(req, ptr_r);
  assign owner_req_s = req[idx_r];

  // Next-state and next-output decode for the IDLE/GRANT sequencer.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    idx_s     = idx_r;
    valid_s   = valid_r;
    timeout_s = 1'b0;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          grant_s = {{(N-1){1'b0}}, 1'b1} << win_s;
          idx_s   = win_s;
          valid_s = 1'b1;
          cnt_s   = 8'd0;
          state_s = GRANT;
        end else begin
          grant_s = {N{1'b0}};
          valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (rel || !owner_req_s || (cnt_r == HOLD_LAST)) begin
          // Timeout is flagged only when expiry is the sole reason to release.
          timeout_s = !rel && owner_req_s;
          grant_s   = {N{1'b0}};
          valid_s   = 1'b0;
          ptr_s     = idx_r + 3'd1;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {N{1'b0}};
        valid_s = 1'b0;
        ptr_s   = 3'd0;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      grant_r   <= {N{1'b0}};
      idx_r     <= 3'd0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      ptr_r     <= 3'd0;
      cnt_r     <= 8'd0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      idx_r     <= idx_s;
      valid_r   <= valid_s;
      timeout_r <= timeout_s;
      ptr_r     <= ptr_s;
      cnt_r     <= cnt_s;
    end
  end

  assign grant       = grant_r;
  assign grant_idx   = idx_r;
  assign grant_valid = valid_r;
  assign timeout     = timeout_r;

endmodule
